ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
Iterative multiply/divide unit for the RV32M extension, placed in the EX stage. It consumes the operand and destination fields held by the ID/EX pipeline register. It stalls the front of the pipeline with `busy` while it computes, then presents the result for one cycle so the EX/MEM register can capture it. Every operation has the same fixed latency, which keeps hazard and stall logic simple.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  EX-stage instruction is an M-extension op (valid qualifier)
flush  input  1  kill in-flight op (branch/exception flush of EX)
funct3_ex  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1Data_ex  input  XLEN  operand A (forwarded value)
rs2Data_ex  input  XLEN  operand B (forwarded value)
rdAddr_ex  input  5  destination register of the op
busy  output  1  stall request to PC/IF_ID/ID_EX enables
done  output  1  result valid this cycle
result  output  XLEN  op result, valid when done=1
rdAddr_mdu  output  5  destination captured at start

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- State machine:
  - IDLE: on start=1 and flush=0, latch operands, funct3 and rdAddr, set cnt=XLEN-1, go to CALC.
  - CALC: one radix-2 iteration per cycle. When cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: one cycle only, then IDLE unconditionally.
- Latency:
  - start seen high in cycle 0 gives CALC in cycles 1..XLEN and DONE in cycle XLEN+1 (33 for XLEN=32).
  - Latency is fixed for all funct3 values and special cases.
- busy = ~reset & ((state==IDLE & start & ~flush) | state==CALC).
  - busy is 0 in DONE, so the stalled pipeline advances on the DONE edge.
  - start is still high for the same instruction in the DONE cycle. It is ignored there, and IDLE is reached next.
- start is ignored in CALC and DONE.
- done=1 only in DONE. result and rdAddr_mdu hold their last values outside DONE.
- Multiply:
  - Shift-add on 2·XLEN-bit product of operand magnitudes.
  - Operand signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/MUL unsigned magnitudes.
  - Product negated at the end when the signs differ.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes (signed for DIV/REM, raw for DIVU/REMU).
  - Quotient sign = signA ^ signB; remainder sign = signA.
- Special cases (override the iteration result, latency unchanged):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
- flush:
  - In CALC or DONE: next state IDLE, done stays 0 the following cycle, no result is emitted.
  - flush with start in IDLE: the op is not accepted.
- reset (any state, including mid-CALC): state=IDLE, cnt=0, done=0, busy=0, result=0, rdAddr_mdu=0, internal accumulators cleared.
- Back-to-back ops: the next op is accepted at the earliest in the cycle after DONE, i.e. one idle cycle between ops.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> busy=1 in cycles 0..32; done=1, result=0xFFFFFFEB, rdAddr_mdu=rdAddr_ex only in cycle 33; busy=0 in cycle 33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each at cycle 33.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all at cycle 33.
- flush in cycle 10 of a DIV -> busy=0 from cycle 11, done never asserts. A new MUL 3×4 at cycle 12 -> result 12 at cycle 45.
- reset in cycle 20 of a MUL -> cycle 21: busy=0, done=0, result=0. Holding start high through DONE -> exactly one done pulse per accepted op.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide unit for the EX stage.
//
// Every operation takes the same fixed latency. If start is accepted in cycle 0,
// the unit iterates in cycles 1..XLEN and presents the result in cycle XLEN+1
// (the DONE cycle). Multiply uses radix-2 shift-add on operand magnitudes.
// Divide uses restoring division on operand magnitudes. Signs are fixed up
// when the result is formed.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          EX-stage instruction is an M op (ignored outside IDLE)
//   flush          kill the in-flight op / refuse a new one
//   funct3_ex      M-extension operation select
//   rs1Data_ex     operand A (forwarded)
//   rs2Data_ex     operand B (forwarded)
//   rdAddr_ex      destination register of the op
//   busy           stall request for PC / IF_ID / ID_EX
//   done           result valid this cycle (DONE state only)
//   result         op result; holds its last value outside DONE
//   rdAddr_mdu     destination of the op in result; holds outside DONE
module ex_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3_ex,
    input  logic [XLEN-1:0] rs1Data_ex,
    input  logic [XLEN-1:0] rs2Data_ex,
    input  logic [4:0]      rdAddr_ex,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdAddr_mdu
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Per-op context captured at acceptance.
    typedef struct packed {
        logic [2:0] f3;
        logic [4:0] rd;
        logic       sign_a;    // operand A treated as negative
        logic       sign_b;    // operand B treated as negative
        logic       div_zero;  // divisor was zero
    } op_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    op_t             op;
    logic [XLEN-1:0] acc_hi;   // mul: running high product / div: partial remainder
    logic [XLEN-1:0] acc_lo;   // mul: multiplier, shifted out / div: dividend -> quotient
    logic [XLEN-1:0] opb;      // mul: multiplicand magnitude / div: divisor magnitude

    logic accept;
    assign accept = (state == IDLE) & start & ~flush;

    // ---------------- operand decode at acceptance ----------------
    logic            in_div, sa_en, sb_en, sign_a_in, sign_b_in;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        in_div    = funct3_ex[2];
        // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
        sa_en     = in_div ? ~funct3_ex[0]
                           : (funct3_ex[1:0] == 2'b01) | (funct3_ex[1:0] == 2'b10);
        sb_en     = in_div ? ~funct3_ex[0] : (funct3_ex[1:0] == 2'b01);
        sign_a_in = sa_en & rs1Data_ex[XLEN-1];
        sign_b_in = sb_en & rs2Data_ex[XLEN-1];
        mag_a     = sign_a_in ? -rs1Data_ex : rs1Data_ex;
        mag_b     = sign_b_in ? -rs2Data_ex : rs2Data_ex;
    end

    // ---------------- one radix-2 iteration ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN+1:0] div_diff;
    logic [XLEN-1:0] hi_nxt, lo_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_sh   = {acc_hi, acc_lo[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b00, opb};
        hi_nxt   = acc_hi;
        lo_nxt   = acc_lo;
        if (op.f3[2]) begin
            // Restoring step: keep the difference only if it did not borrow.
            // The remainder stays below the divisor, so it fits in XLEN bits.
            if (!div_diff[XLEN+1]) begin
                hi_nxt = div_diff[XLEN-1:0];
                lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_sh[XLEN-1:0];
                lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            // Add-then-shift: the carry of the add drops into the high half.
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    // ---------------- result formatting (from the final iteration) ----------------
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, res_nxt;

    always_comb begin
        prod   = {hi_nxt, lo_nxt};
        prod_s = (op.sign_a ^ op.sign_b) ? -prod : prod;
        // A zero divisor leaves an all-ones quotient and the dividend magnitude as
        // the remainder. Suppressing only the quotient negation gives -1 and rs1.
        // The signed-overflow case (MIN / -1) falls out naturally: |MIN| / 1 = MIN,
        // and negating it gives MIN again, with a zero remainder.
        quo_s  = ((op.sign_a ^ op.sign_b) & ~op.div_zero) ? -lo_nxt : lo_nxt;
        rem_s  = op.sign_a ? -hi_nxt : hi_nxt;
        unique case (op.f3)
            3'b000:                res_nxt = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_nxt = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:        res_nxt = quo_s;
            default:               res_nxt = rem_s;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (flush)         state_nxt = IDLE;
                else if (cnt == 0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = ~reset & (accept | (state == CALC));
    assign done = (state == DONE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            op         <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opb        <= '0;
            result     <= '0;
            rdAddr_mdu <= '0;
        end else if (accept) begin
            cnt         <= CW'(XLEN - 1);
            op.f3       <= funct3_ex;
            op.rd       <= rdAddr_ex;
            op.sign_a   <= sign_a_in;
            op.sign_b   <= sign_b_in;
            op.div_zero <= (rs2Data_ex == '0);
            acc_hi      <= '0;
            acc_lo      <= in_div ? mag_a : mag_b;
            opb         <= in_div ? mag_b : mag_a;
        end else if ((state == CALC) && !flush) begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            if (cnt != 0) begin
                cnt <= cnt - 1'b1;
            end else begin
                // Final iteration: publish the result as DONE is entered.
                result     <= res_nxt;
                rdAddr_mdu <= op.rd;
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu (XLEN=32).
// Cycle 0 of an op is the cycle in which start is first driven high. Outputs
// are sampled on the falling edge.
module tb_ex_mdu;

    logic        clk, reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_mdu;

    int n_chk  = 0;
    int n_pass = 0;

    ex_mdu #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .flush      (flush),
        .funct3_ex  (funct3),
        .rs1Data_ex (rs1),
        .rs2Data_ex (rs2),
        .rdAddr_ex  (rd_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rdAddr_mdu (rd_mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    // Run one op and hold start high through DONE. Operands are scrambled in cycle 1
    // so the results depend on the values captured at acceptance.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int          done_cnt, done_cyc;
        logic        busy_ok, busy_at_done;
        logic [31:0] res;
        logic [4:0]  rdo;
        done_cnt = 0; done_cyc = -1; busy_ok = 1'b1; busy_at_done = 1'b1;
        res = '0; rdo = '0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
        for (int c = 0; c <= 34; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 1) begin
                    rs1 = 32'hDEADBEEF; rs2 = 32'h0; rd_in = ~rd;
                end
            end
            @(negedge clk);
            if (c <= 32 && busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_cnt++; done_cyc = c; res = result; rdo = rd_mdu; busy_at_done = busy;
            end
            if (c == 34 && busy !== 1'b0) busy_ok = 1'b0;
            if (c == 33) start = 1'b0;
        end
        check({tag, " busy"},       32'(busy_ok),      32'd1);
        check({tag, " done_cnt"},   32'(done_cnt),     32'd1);
        check({tag, " done_cyc"},   32'(done_cyc),     32'd33);
        check({tag, " busy@done"},  32'(busy_at_done), 32'd0);
        check({tag, " result"},     res,               exp);
        check({tag, " rd"},         32'(rdo),          32'(rd));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
        rs1 = '0; rs2 = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy",   32'(busy),   32'd0);
        check("rst done",   32'(done),   32'd0);
        check("rst result", result,      32'd0);
        check("rst rd",     32'(rd_mdu), 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        do_op("MUL 7*-3",       3'b000, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        do_op("MULHU -1*-1",    3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE);
        do_op("MULH min*min",   3'b001, 32'h80000000,   32'h80000000, 5'd7,  32'h40000000);
        do_op("MULHSU -1*2",    3'b010, 32'hFFFFFFFF,   32'd2,        5'd8,  32'hFFFFFFFF);
        do_op("MULH -1*-1",     3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd9,  32'h00000000);
        do_op("DIV -7/2",       3'b100, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFD);
        do_op("REM -7/2",       3'b110, 32'hFFFFFFF9,   32'd2,        5'd11, 32'hFFFFFFFF);
        do_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,        5'd12, 32'd14);
        do_op("REMU 100/7",     3'b111, 32'd100,        32'd7,        5'd13, 32'd2);
        do_op("DIV 20/-3",      3'b100, 32'd20,         32'hFFFFFFFD, 5'd14, 32'hFFFFFFFA);
        do_op("REM 20/-3",      3'b110, 32'd20,         32'hFFFFFFFD, 5'd15, 32'd2);
        do_op("DIVU 5/0",       3'b101, 32'd5,          32'd0,        5'd16, 32'hFFFFFFFF);
        do_op("REMU 5/0",       3'b111, 32'd5,          32'd0,        5'd17, 32'd5);
        do_op("DIV 7/0",        3'b100, 32'd7,          32'd0,        5'd18, 32'hFFFFFFFF);
        do_op("REM -7/0",       3'b110, 32'hFFFFFFF9,   32'd0,        5'd19, 32'hFFFFFFF9);
        do_op("DIV min/-1",     3'b100, 32'h80000000,   32'hFFFFFFFF, 5'd20, 32'h80000000);
        do_op("REM min/-1",     3'b110, 32'h80000000,   32'hFFFFFFFF, 5'd21, 32'd0);

        // start together with flush in IDLE is refused
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd1;
        @(negedge clk);
        check("idle flush busy", 32'(busy), 32'd0);
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle flush not accepted", 32'(busy), 32'd0);

        // flush in cycle 10 of a DIV, then MUL 3*4 from cycle 12 (done at cycle 45)
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd22;
        dc = 0;
        @(negedge clk);
        check("flush c0 busy", 32'(busy), 32'd1);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 1)  start = 1'b0;
            if (c == 10) flush = 1'b1;
            if (c == 11) flush = 1'b0;
            @(negedge clk);
            if (done === 1'b1) dc++;
            if (c == 10) check("flush c10 busy", 32'(busy), 32'd1);
            if (c == 11) check("flush c11 busy", 32'(busy), 32'd0);
        end
        check("flush no done", 32'(dc), 32'd0);
        do_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 5'd23, 32'd12);

        // reset in cycle 20 of a MUL
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6; rd_in = 5'd24;
        dc = 0;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk); #1;
            if (c == 1)  start = 1'b0;
            if (c == 20) reset = 1'b1;
            if (c == 21) reset = 1'b0;
            @(negedge clk);
            if (done === 1'b1) dc++;
            if (c == 20) check("rst c20 busy", 32'(busy), 32'd0);
            if (c == 21) begin
                check("rst c21 busy",   32'(busy),   32'd0);
                check("rst c21 done",   32'(done),   32'd0);
                check("rst c21 result", result,      32'd0);
                check("rst c21 rd",     32'(rd_mdu), 32'd0);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) dc++;
        end
        check("rst no done", 32'(dc), 32'd0);
        do_op("MULHU after rst", 3'b011, 32'h00010000, 32'h00030000, 5'd25, 32'h00000003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
